timer_counter: RTL and testbench
================================

Name: timer_counter

Overview:
- 16-bit timer/counter block, equivalent to an 8051-style Timer in 16-bit mode.
- Timer mode (c_t=0): counts system clock cycles.
- Counter mode (c_t=1): counts falling edges of the external input cin.
- Counting is enabled by the run control tr, optionally qualified by an external gate pin intx when gate=1. The block sits beside the CPU core as a free-running event/time counter whose value is exposed on count.

Parameters:
- WIDTH, 16, counter width in bits; count wraps modulo 2^WIDTH.
- SYNC_STAGES, 2, number of synchronizer flops on the asynchronous inputs cin and intx.

Ports:
- clk    input  1      system clock; all state updates on the rising edge.
- reset  input  1      synchronous, active-low reset; sampled on the rising edge of clk.
- gate   input  1      1 = counting additionally requires intx high; 0 = intx ignored.
- intx   input  1      external gate pin; asynchronous, synchronized internally.
- tr     input  1      run control; 0 = count frozen.
- cin    input  1      external count input used in counter mode; asynchronous, synchronized internally.
- c_t    input  1      mode select; 0 = timer (clk cycles), 1 = counter (cin falling edges).
- count  output WIDTH  current counter value, driven directly from a register.

Behaviour:
- Reset: when reset=0 at a rising edge, count <= 0 and all synchronizer/edge flops <= 0. Reset has priority over counting, including in the middle of a count.
- Synchronization:
  - cin passes through SYNC_STAGES flops, then one history flop.
  - fall_evt = history & ~sync_out, i.e. a 1->0 transition of the synchronized cin.
  - intx passes through SYNC_STAGES flops to give intx_s.
  - gate, tr and c_t are treated as synchronous control signals and used unregistered.
- Run enable: run = tr & (~gate | intx_s).
- Increment condition at each rising edge with reset=1:
  - timer mode: run & (c_t==0) -> count <= count+1, i.e. one increment per clock while run.
  - counter mode: run & (c_t==1) & fall_evt -> count <= count+1.
  - otherwise count holds.
- Latency:
  - Counter mode: the first rising edge that samples cin=0 after cin was high is edge k; count changes at edge k+SYNC_STAGES (k+2 by default).
  - Timer mode: an increment occurs at the first edge where tr=1 and gate permits. An intx rise affects run SYNC_STAGES edges after it is first sampled.
- Input width requirement: cin must be stable high for ≥2 clk periods and low for ≥2 clk periods to be guaranteed counted. Narrower pulses may be missed. Rising edges never count.
- Wrap-around: 0xFFFF + 1 -> 0x0000 with no stall and no overflow output.
- Mode switch: the synchronizer and history flops track cin continuously regardless of c_t or run. Changing c_t therefore never creates a spurious increment; count keeps its value across the switch.
- Falling edges of cin while run=0 are discarded, not queued.
- gate=1 with intx_s=0 freezes count in both modes even when tr=1.
- No X propagation: count is fully defined from the first reset onward.

Decomposition:
- Shared package timer_pkg:
  - WIDTH default (16);
  - mode constants MODE_TIMER=1'b0 and MODE_COUNTER=1'b1.
- One sub-module, sync_edge_det:
  - parameterized SYNC_STAGES synchronizer plus history flop, synchronous active-low reset to 0;
  - outputs the synchronized level and a one-cycle fall pulse.
  - Instantiated twice: cin uses the fall pulse; intx uses the level only.
- The top module holds the run logic and the WIDTH-bit count register.

Test Plan:
- Reset: hold reset=0 for 2 edges with tr=1 and c_t=0 -> count=0. Release -> count reads 1, 2, 3... on successive edges.
- Timer run/stop:
  - reset released, tr=1, gate=0, c_t=0 for 10 edges -> count=10.
  - tr=0 for 5 edges -> count stays 10.
- Counter mode:
  - c_t=1, tr=1, gate=0; apply 10 cin pulses, each 3 clk high / 3 clk low -> count increments by exactly 10.
  - Each increment lands 2 edges after cin is sampled low.
  - Pulses narrower than 1 clk are not required to count.
- Gate control:
  - gate=1, intx=0, tr=1, c_t=0 for 20 edges -> count unchanged.
  - Raise intx -> count starts incrementing 2 edges later, one per clock.
- Wrap: preload by running timer mode until count=0xFFFE, then 2 edges -> count=0xFFFF, then 0x0000.
- Mode switch / reset mid-run:
  - Toggle c_t 0->1 with cin held low or high -> no extra increment.
  - Assert reset=0 mid-count -> count=0 at that edge.

Source files
------------

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared constants for the 16-bit timer/counter block.
//                TIMER_WIDTH        - default counter width in bits
//                TIMER_SYNC_STAGES  - default synchronizer depth on async pins
//                MODE_TIMER/COUNTER - encodings of the c_t mode select
//  Revision    : 1.0  initial release
// ============================================================================
package timer_pkg;

    localparam int   TIMER_WIDTH       = 16;
    localparam int   TIMER_SYNC_STAGES = 2;

    localparam logic MODE_TIMER        = 1'b0;   // count clk cycles
    localparam logic MODE_COUNTER      = 1'b1;   // count cin falling edges

endpackage : timer_pkg
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_det
//  Description : Multi-flop synchronizer for an asynchronous input, followed by
//                a history flop used to detect 1->0 transitions of the
//                synchronized level.
//  Ports       : clk    - system clock
//                reset  - synchronous active-low reset, clears all flops to 0
//                din    - asynchronous input
//                level  - synchronized level of din
//                fall   - one-cycle pulse on a 1->0 change of level
//  Revision    : 1.0  initial release
// ============================================================================
module sync_edge_det
    import timer_pkg::*;
#(
    parameter int SYNC_STAGES = TIMER_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign level = r_sync[SYNC_STAGES-1];

    // History still high while the synchronized level has just dropped.
    assign fall  = r_hist & ~r_sync[SYNC_STAGES-1];

endmodule : sync_edge_det
`default_nettype wire

// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
//  Module      : timer_counter
//  Description : 8051-style 16-bit timer/counter. In timer mode (c_t=0) it
//                counts clk cycles; in counter mode (c_t=1) it counts falling
//                edges of the external cin pin. Counting requires tr=1 and,
//                when gate=1, a high synchronized intx.
//  Ports       : clk    - system clock
//                reset  - synchronous active-low reset
//                gate   - 1: counting also needs intx high
//                intx   - external gate pin (asynchronous)
//                tr     - run control
//                cin    - external count input (asynchronous)
//                c_t    - mode select (0 timer, 1 counter)
//                count  - registered counter value
//  Revision    : 1.0  initial release
// ============================================================================
module timer_counter
    import timer_pkg::*;
#(
    parameter int WIDTH       = TIMER_WIDTH,
    parameter int SYNC_STAGES = TIMER_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gate,
    input  logic             intx,
    input  logic             tr,
    input  logic             cin,
    input  logic             c_t,
    output logic [WIDTH-1:0] count
);

    logic             w_cin_level_unused;
    logic             w_cin_fall;
    logic             w_intx_s;
    logic             w_intx_fall_unused;
    logic             w_run;
    logic             w_inc;
    logic [WIDTH-1:0] r_count;

    // The cin synchronizer runs regardless of mode or run so that switching
    // c_t never exposes a stale history bit as a fresh falling edge.
    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cin_sync (
        .clk   (clk),
        .reset (reset),
        .din   (cin),
        .level (w_cin_level_unused),
        .fall  (w_cin_fall)
    );

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_intx_sync (
        .clk   (clk),
        .reset (reset),
        .din   (intx),
        .level (w_intx_s),
        .fall  (w_intx_fall_unused)
    );

    assign w_run = tr & (~gate | w_intx_s);

    // A falling edge seen while not running is simply dropped.
    assign w_inc = w_run & ((c_t == MODE_TIMER) |
                            ((c_t == MODE_COUNTER) & w_cin_fall));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_inc) begin
            r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};  // wraps naturally
        end
    end

    assign count = r_count;

endmodule : timer_counter
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_counter
//  Description : Self-checking bench for timer_counter: a vector table for the
//                reset/run/stop behaviour, directed sequences for latency,
//                gating, wrap, mode switch and mid-run reset, and a random
//                phase compared against a time-indexed behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        gate = 1'b0;
    logic        intx = 1'b0;
    logic        tr = 1'b0;
    logic        cin = 1'b0;
    logic        c_t = 1'b0;
    logic [15:0] count;

    int checks = 0;
    int errors = 0;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .gate  (gate),
        .intx  (intx),
        .tr    (tr),
        .cin   (cin),
        .c_t   (c_t),
        .count (count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // Inputs are remembered by the edge at which they were sampled. An input
    // sampled at edge t becomes visible to the counting decision at edge t+2
    // (two-stage synchronizer); a cin fall is a 1 at t-3 followed by 0 at t-2.
    // Samples taken at or before the last reset edge read as 0.
    bit          cin_at  [8];
    bit          intx_at [8];
    int          edge_no  = 0;
    int          rst_edge = 0;
    logic [15:0] exp_count = 16'h0;

    function automatic bit past(input bit arr [8], input int t, input int d, input int re);
        if (t - d <= re) return 1'b0;
        return arr[(t - d) & 7];
    endfunction

    task automatic tick();
        bit run_m, fall_m;
        @(posedge clk);
        edge_no++;
        cin_at[edge_no & 7]  = cin;
        intx_at[edge_no & 7] = intx;
        if (!reset) begin
            exp_count = 16'h0;
            rst_edge  = edge_no;
        end else begin
            run_m  = tr && (!gate || past(intx_at, edge_no, 2, rst_edge));
            fall_m = past(cin_at, edge_no, 3, rst_edge) && !past(cin_at, edge_no, 2, rst_edge);
            if (run_m && (c_t == 1'b0 || fall_m)) exp_count = exp_count + 16'h1;
        end
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          rst_n;
        bit          tr_v;
        bit          gate_v;
        bit          intx_v;
        bit          ct_v;
        bit          cin_v;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [17];

    initial begin
        logic [15:0] base;
        logic [15:0] v;

        // 2 reset edges, 10 running edges, 5 stopped edges
        for (int i = 0; i < 17; i++) begin
            vecs[i].rst_n  = (i >= 2);
            vecs[i].tr_v   = (i < 12);
            vecs[i].gate_v = 1'b0;
            vecs[i].intx_v = 1'b0;
            vecs[i].ct_v   = 1'b0;
            vecs[i].cin_v  = 1'b0;
            vecs[i].exp    = (i < 2) ? 16'd0 : (i < 12) ? 16'(i - 1) : 16'd10;
        end

        for (int i = 0; i < 17; i++) begin
            reset = vecs[i].rst_n;
            tr    = vecs[i].tr_v;
            gate  = vecs[i].gate_v;
            intx  = vecs[i].intx_v;
            c_t   = vecs[i].ct_v;
            cin   = vecs[i].cin_v;
            tick();
            check($sformatf("table_row%0d", i), count, vecs[i].exp);
        end

        // ---------------- counter mode, 10 pulses 3 high / 3 low ----------------
        reset = 1'b0; tick();
        reset = 1'b1; tr = 1'b1; gate = 1'b0; c_t = 1'b1; cin = 1'b1;
        ticks(3);
        base = count;
        check("counter_start_no_rise_count", base, 16'd0);
        for (int p = 0; p < 10; p++) begin
            cin = 1'b0;
            tick();
            tick();
            if (p == 0) check("counter_latency_k1", count, 16'd0);
            tick();
            if (p == 0) check("counter_latency_k2", count, 16'd1);
            cin = 1'b1;
            ticks(3);
        end
        check("counter_ten_pulses", count, 16'd10);

        // falling edge while stopped is discarded
        tr = 1'b0; cin = 1'b0; ticks(4);
        tr = 1'b1; ticks(4);
        check("fall_while_stopped", count, 16'd10);

        // ---------------- gate control ----------------
        reset = 1'b0; tick();
        reset = 1'b1; gate = 1'b1; intx = 1'b0; tr = 1'b1; c_t = 1'b0;
        ticks(20);
        check("gate_frozen", count, 16'd0);
        intx = 1'b1;
        tick();
        tick();
        check("gate_intx_latency_k1", count, 16'd0);
        tick();
        check("gate_intx_latency_k2", count, 16'd1);
        ticks(3);
        check("gate_running", count, 16'd4);
        intx = 1'b0; ticks(2);
        v = count; ticks(5);
        check("gate_refrozen", count, v);
        gate = 1'b0; intx = 1'b0;

        // ---------------- mode switch ----------------
        c_t = 1'b0; cin = 1'b0; ticks(5);
        v = count;
        c_t = 1'b1; ticks(4);
        check("mode_switch_cin_low", count, v);
        c_t = 1'b0; cin = 1'b1; ticks(4);
        check("timer_after_switch", count, v + 16'd4);
        v = count;
        c_t = 1'b1; ticks(4);
        check("mode_switch_cin_high", count, v);

        // ---------------- reset mid-run ----------------
        c_t = 1'b0; ticks(3);
        reset = 1'b0; tick();
        check("reset_mid_run", count, 16'd0);
        reset = 1'b1; tick();
        check("count_after_reset", count, 16'd1);

        // ---------------- wrap-around ----------------
        reset = 1'b0; tick();
        reset = 1'b1; tr = 1'b1; gate = 1'b0; c_t = 1'b0;
        ticks(16'hFFFE);
        check("wrap_preload", count, 16'hFFFE);
        tick();
        check("wrap_ffff", count, 16'hFFFF);
        tick();
        check("wrap_zero", count, 16'h0000);

        // ---------------- random phase against the model ----------------
        reset = 1'b0; tick();
        check("model_reset", count, exp_count);
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) != 0);
            tr    = ($urandom_range(0, 9) < 8);
            gate  = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 9) < 2) intx = ~intx;
            if ($urandom_range(0, 19) == 0) c_t = ~c_t;
            if ($urandom_range(0, 9) < 3) cin = ~cin;
            tick();
            check($sformatf("random_cycle%0d", i), count, exp_count);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_timer_counter
`default_nettype wire
